// File: rtl/led_scan_driver.sv
// Multiplexed 7-segment scan driver with PWM dimming, dead time and frame-synchronous double buffering.
// Optional per-digit blinking is compiled in when LED_SCAN_BLINK_EN is defined.
module led_scan_driver #(
    parameter int unsigned DIGITS          = 8,
    parameter int unsigned TICKS_PER_DIGIT = 20000,
    parameter int unsigned PWM_BITS        = 4,
    parameter int unsigned BLINK_FRAMES    = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     enable,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blink,
    input  logic                  load,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic                  update_pending,
    output logic                  frame_start,
    output logic [7:0]            SSEG_CA,
    output logic [DIGITS-1:0]     SSEG_AN
);

    localparam int unsigned TW = $clog2(TICKS_PER_DIGIT);
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned XW = (TW > PWM_BITS) ? TW : PWM_BITS;
    localparam logic [TW-1:0] LAST_TICK  = TW'(TICKS_PER_DIGIT - 1);
    localparam logic [IW-1:0] LAST_DIGIT = IW'(DIGITS - 1);

    logic [TW-1:0]         timer_q;
    logic [IW-1:0]         index_q;
    logic [4*DIGITS-1:0]   pend_value_q, act_value_q;
    logic [DIGITS-1:0]     pend_enable_q, act_enable_q;
    logic [DIGITS-1:0]     pend_dp_q, act_dp_q;

    logic                  slot_end;
    logic                  frame_wrap;
    logic [3:0]            cur_nibble;
    logic [6:0]            glyph;
    logic [XW-1:0]         timer_ext;
    logic                  pwm_on;
    logic                  blanked;
    logic [DIGITS-1:0]     an_next;

    assign slot_end   = (timer_q == LAST_TICK);
    assign frame_wrap = slot_end && (index_q == LAST_DIGIT);

`ifdef LED_SCAN_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);

    logic [DIGITS-1:0] pend_blink_q, act_blink_q;
    logic [FW-1:0]     frame_cnt_q;
    logic              blink_phase_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_blink_q  <= '0;
            act_blink_q   <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            if (load) pend_blink_q <= blink;
            if (frame_wrap) begin
                if (update_pending) act_blink_q <= pend_blink_q;
                if (frame_cnt_q == LAST_FRAME) begin
                    frame_cnt_q   <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    assign blanked = act_blink_q[index_q] && blink_phase_q;
`else
    logic unused_blink;
    assign unused_blink = ^{blink, BLINK_FRAMES};
    assign blanked      = 1'b0;
`endif

    always_comb begin
        cur_nibble = act_value_q[{index_q, 2'b00} +: 4];
        // Active-low gfedcba
        unique case (cur_nibble)
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h27;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    always_comb begin
        timer_ext = XW'(timer_q);
        pwm_on    = (timer_ext[PWM_BITS-1:0] < brightness) || (&brightness);
        an_next   = '1;
        // Slot timer 0 is dead time so the previous digit's anode is fully off first
        if ((timer_q != '0) && act_enable_q[index_q] && pwm_on && !blanked) begin
            an_next[index_q] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            timer_q        <= '0;
            index_q        <= '0;
            frame_start    <= 1'b0;
            update_pending <= 1'b0;
            pend_value_q   <= '0;
            pend_enable_q  <= '0;
            pend_dp_q      <= '0;
            act_value_q    <= '0;
            act_enable_q   <= '0;
            act_dp_q       <= '0;
            SSEG_CA        <= 8'hFF;
            SSEG_AN        <= '1;
        end else begin
            if (slot_end) begin
                timer_q <= '0;
                index_q <= (index_q == LAST_DIGIT) ? '0 : index_q + 1'b1;
            end else begin
                timer_q <= timer_q + 1'b1;
            end
            frame_start <= frame_wrap;

            // Transfer happens on the wrap edge, so a load seen alongside frame_start waits a frame
            if (frame_wrap && update_pending) begin
                act_value_q  <= pend_value_q;
                act_enable_q <= pend_enable_q;
                act_dp_q     <= pend_dp_q;
            end
            if (load) begin
                pend_value_q   <= value;
                pend_enable_q  <= enable;
                pend_dp_q      <= dp;
                update_pending <= 1'b1;
            end else if (frame_wrap) begin
                update_pending <= 1'b0;
            end

            SSEG_CA <= {~act_dp_q[index_q], glyph};
            SSEG_AN <= an_next;
        end
    end

endmodule

// File: tb/tb_led_scan_driver.sv
// Self-checking bench for led_scan_driver: randomized loads against a cycle-count based reference model.
module tb_led_scan_driver;

    localparam int D = 4;
    localparam int T = 8;
    localparam int P = 2;
    localparam int B = 2;
    localparam int F = T * D;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic [4*D-1:0] value;
    logic [D-1:0]   enable;
    logic [D-1:0]   dp;
    logic [D-1:0]   blink;
    logic           load;
    logic [P-1:0]   brightness;
    logic           update_pending;
    logic           frame_start;
    logic [7:0]     SSEG_CA;
    logic [D-1:0]   SSEG_AN;

    led_scan_driver #(
        .DIGITS(D),
        .TICKS_PER_DIGIT(T),
        .PWM_BITS(P),
        .BLINK_FRAMES(B)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .value(value),
        .enable(enable),
        .dp(dp),
        .blink(blink),
        .load(load),
        .brightness(brightness),
        .update_pending(update_pending),
        .frame_start(frame_start),
        .SSEG_CA(SSEG_CA),
        .SSEG_AN(SSEG_AN)
    );

    always #5 clk = ~clk;

    int tests;
    int fails;
    int n;
    logic [15:0] m_pval, m_aval;
    logic [3:0]  m_pen, m_aen, m_pdp, m_adp, m_pbl, m_abl;
    logic        m_upd;

    // Standard active-high gfedcba patterns
    function automatic logic [6:0] seg_on(input logic [3:0] nib);
        case (nib)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h58;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, n);
        end
    endtask

    task automatic clear_model();
        m_pval = '0; m_aval = '0;
        m_pen = '0; m_aen = '0; m_pdp = '0; m_adp = '0; m_pbl = '0; m_abl = '0;
        m_upd = 1'b0;
    endtask

    // Advance one clock: predict outputs from the state of cycle n, then compare in cycle n+1
    task automatic step();
        int tmr;
        int idx;
        logic on;
        logic ph;
        logic boundary;
        logic [3:0] e_an;
        logic [7:0] e_ca;
        tmr = n % T;
        idx = (n / T) % D;
        e_ca = {~m_adp[idx], ~seg_on(m_aval[idx*4 +: 4])};
        on = ((tmr % 4) < int'(brightness)) || (brightness == 2'b11);
`ifdef LED_SCAN_BLINK_EN
        ph = (((n / F) / B) % 2) == 1;
`else
        ph = 1'b0;
`endif
        e_an = 4'b1111;
        if (tmr != 0 && m_aen[idx] && on && !(ph && m_abl[idx])) e_an[idx] = 1'b0;
        boundary = ((n + 1) % F) == 0;
        if (boundary && m_upd) begin
            m_aval = m_pval; m_aen = m_pen; m_adp = m_pdp; m_abl = m_pbl;
        end
        if (load) begin
            m_pval = value; m_pen = enable; m_pdp = dp; m_pbl = blink;
            m_upd = 1'b1;
        end else if (boundary) begin
            m_upd = 1'b0;
        end
        @(posedge clk);
        #1;
        n++;
        load = 1'b0;
        check("anodes", 32'(SSEG_AN), 32'(e_an));
        check("cathodes", 32'(SSEG_CA), 32'(e_ca));
        check("frame_start", 32'(frame_start), 32'((n % F) == 0));
        check("update_pending", 32'(update_pending), 32'(m_upd));
    endtask

    task automatic do_reset(input int cycles);
        reset_n = 1'b0;
        load = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        n = 0;
        clear_model();
        check("rst_an", 32'(SSEG_AN), 32'h0000000F);
        check("rst_ca", 32'(SSEG_CA), 32'h000000FF);
        check("rst_upd", 32'(update_pending), 32'h0);
        check("rst_fs", 32'(frame_start), 32'h0);
        reset_n = 1'b1;
    endtask

    task automatic load_random();
        value = 16'($urandom);
        enable = 4'($urandom);
        dp = 4'($urandom);
        blink = 4'($urandom);
        load = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_dark;
        tests = 0;
        fails = 0;
        n = 0;
        value = '0; enable = '0; dp = '0; blink = '0; load = 1'b0; brightness = 2'b11;
        clear_model();

        do_reset(3);

        // Basic scan of 1A2F at full brightness
        repeat (2) step();
        value = 16'h1A2F; enable = 4'hF; dp = 4'h0; blink = 4'h0; load = 1'b1;
        step();
        while (n < F + 1) step();
        check("dead_an", 32'(SSEG_AN), 32'h0000000F);
        step();
        check("slot0_ca", 32'(SSEG_CA), 32'h0000008E);
        check("slot0_an", 32'(SSEG_AN), 32'h0000000E);
        while (n < F + T + 2) step();
        check("slot1_ca", 32'(SSEG_CA), 32'h000000A4);
        check("slot1_an", 32'(SSEG_AN), 32'h0000000D);

        // Load coincident with frame_start is held a whole frame
        while ((n % F) != 0) step();
        check("fs_seen", 32'(frame_start), 32'h1);
        load_random();
        step();
        check("held_upd", 32'(update_pending), 32'h1);
        while ((n % F) != F - 1) step();
        check("held_upd_end", 32'(update_pending), 32'h1);
        repeat (2) step();

        // Randomized loads and brightness changes
        for (int f = 0; f < 6; f++) begin
            for (int c = 0; c < F; c++) begin
                if ($urandom_range(0, 7) == 0) load_random();
                if ($urandom_range(0, 15) == 0) brightness = 2'($urandom_range(0, 3));
                step();
            end
        end

        // PWM at brightness 1 then 0
        value = 16'($urandom); enable = 4'hF; dp = 4'($urandom); blink = 4'h0; load = 1'b1;
        brightness = 2'b01;
        step();
        while ((n % F) != 0) step();
        repeat (F) step();
        brightness = 2'b00;
        repeat (F) step();

        // Blink on digit 0
        brightness = 2'b11;
        do_reset(2);
        step();
        value = 16'($urandom); enable = 4'hF; dp = 4'h0; blink = 4'b0001; load = 1'b1;
        step();
`ifdef LED_SCAN_BLINK_EN
        exp_dark = 4'b1111;
`else
        exp_dark = 4'b1110;
`endif
        while (n < 2 * F + 2) step();
        check("blink_dark", 32'(SSEG_AN), 32'(exp_dark));
        while (n < 4 * F + 2) step();
        check("blink_lit", 32'(SSEG_AN), 32'h0000000E);
        while (n < 6 * F) step();

        // Reset mid-slot at index 2 with an update pending
        while (!(((n / T) % D) == 2 && (n % T) == 3)) step();
        load_random();
        enable = 4'hF;
        step();
        check("mid_upd", 32'(update_pending), 32'h1);
        do_reset(1);
        repeat (2) step();
        check("post_rst_an", 32'(SSEG_AN), 32'h0000000F);
        check("post_rst_ca", 32'(SSEG_CA), 32'h000000C0);
        repeat (F + 4) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_scan_driver.md
LED_SCAN_DRIVER -- requirements
Module: led_scan_driver

Interface
REQ-001 SHALL provide parameter DIGITS, default 8: number of multiplexed digits, legal range 1..16.
REQ-002 SHALL provide parameter TICKS_PER_DIGIT, default 20000: clk cycles per digit slot, legal range 4..2^20.
REQ-003 SHALL provide parameter PWM_BITS, default 4: brightness resolution, legal range 1..8.
REQ-004 SHALL provide parameter BLINK_FRAMES, default 64: full frames per blink half-period, legal range 1..1023.
REQ-005 SHALL provide port clk  in  1: single clock; all logic on its rising edge.
REQ-006 SHALL provide port reset_n  in  1: synchronous, active-low reset.
REQ-007 SHALL provide port value  in  4*DIGITS: hex nibble per digit; digit i is value[4i+3:4i].
REQ-008 SHALL provide port enable  in  DIGITS: per-digit display enable.
REQ-009 SHALL provide port dp  in  DIGITS: per-digit decimal point, 1 = lit.
REQ-010 SHALL provide port blink  in  DIGITS: per-digit blink request.
REQ-011 SHALL provide port load  in  1: one-cycle strobe that captures value/enable/dp/blink.
REQ-012 SHALL provide port brightness  in  PWM_BITS: duty setting; all-ones = full on.
REQ-013 SHALL provide port update_pending  out  1: captured data not yet applied to the display.
REQ-014 SHALL provide port frame_start  out  1: one-cycle pulse at each frame boundary.
REQ-015 SHALL provide port SSEG_CA  out  8: active-low segments; bit 7 = DP, bits 6..0 = g..a.
REQ-016 SHALL provide port SSEG_AN  out  DIGITS: active-low digit anodes.

Function
REQ-017 SHALL count a slot timer 0..TICKS_PER_DIGIT-1; at terminal count the timer SHALL return to 0 and digit index SHALL advance, wrapping DIGITS-1 -> 0.
REQ-018 SHALL treat index wrap to 0 as the frame boundary: frame_start high for exactly that cycle.
REQ-019 SHALL on load=1 copy inputs into pending registers and set update_pending the next cycle; multiple loads before a boundary: last wins.
REQ-020 SHALL at a frame boundary copy pending to active registers and clear update_pending, if set; a load in the boundary cycle itself SHALL be held until the following boundary (update_pending stays 1).
REQ-021 SHALL decode the active nibble of the current index: 0-9 standard, A b c d E F as hex glyphs; CA[7] = ~dp[index].
REQ-022 SHALL register SSEG_CA and SSEG_AN; outputs reflect index/timer state with exactly 1 cycle latency.
REQ-023 SHALL drive all anodes off (all ones) during slot timer value 0 (dead time, anti-ghosting).
REQ-024 SHALL drive only anode [index] low when enabled, not dead time, and PWM-on; otherwise all ones.
REQ-025 SHALL define PWM-on as (timer mod 2^PWM_BITS) < brightness, or brightness all-ones; brightness 0 = dark.
REQ-026 SHALL drive SSEG_CA with the decoded glyph even when anodes are off.

Reset
REQ-027 SHALL, while reset_n=0 at a clk edge, set SSEG_AN all ones, SSEG_CA 8'hFF, timer 0, index 0, active and pending registers 0, update_pending 0, frame_start 0, blink phase 0.
REQ-028 SHALL abandon any pending load on reset mid-operation; first slot after release starts at index 0, timer 0.

Configuration
REQ-029 SHALL compile blinking under macro LED_SCAN_BLINK_EN: when defined, a frame counter SHALL toggle blink phase every BLINK_FRAMES frame boundaries and digits with active blink=1 SHALL be blanked (anode off) while phase=1.
REQ-030 SHALL, when LED_SCAN_BLINK_EN is undefined, omit frame counter and blink phase; blink input ignored, display never blanked for blink.

Verification (DIGITS=4, TICKS_PER_DIGIT=8, PWM_BITS=2, BLINK_FRAMES=2)
REQ-031 SHALL check reset: reset_n=0 for 3 cycles -> SSEG_AN=4'b1111, SSEG_CA=8'hFF, update_pending=0.
REQ-032 SHALL check scan: load value=16'h1A2F, enable=4'hF, brightness=2'b11 -> after boundary, slot 0 CA=8'b10001110 (F), slot 1 CA=8'b10100100 (2), AN=4'b1110 then 4'b1101, anodes 1111 at every slot timer value 0, frame_start every 32 cycles.
REQ-033 SHALL check boundary load: load coincident with frame_start -> update_pending stays 1, display unchanged for 32 cycles, applied at next boundary.
REQ-034 SHALL check PWM: brightness=2'b01 -> anode low only where timer mod 4 = 0, excluding dead time; brightness=0 -> AN=4'b1111 throughout.
REQ-035 SHALL check blink (macro defined): blink=4'b0001 -> digit 0 dark in frames 2-3, lit in 0-1 and 4-5; macro undefined -> digit 0 always lit.
REQ-036 SHALL check reset mid-slot at index 2 with update_pending=1 -> next slot index 0, update_pending=0, display blank (enable=0).
